// File: rtl/led_driver_pkg.sv
// Shared definitions for the LED pattern driver.
// Holds the display-mode encoding, the bounce direction encoding, the
// mode-advance helper and the pattern-decode function used by the top level.
// Optional build macro consumed elsewhere: LED_DIM_EN (PWM dimming of the
// output pattern, see led_pattern_driver.sv).
package led_driver_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_WALK   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_FILL   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;

  // Bounce direction: "up" moves towards the highest LED index.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest LED vector the decode helper can produce.
  localparam int MAX_LEDS = 32;
  // Width of the position argument of the decode helper.
  localparam int DEC_POS_W = 8;

  // Mode sequence WALK -> FILL -> BOUNCE -> WALK. The unused code 3 is
  // treated as WALK, so it advances to FILL.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] mode);
    logic [MODE_W-1:0] nm;
    case (mode)
      MODE_FILL:   nm = MODE_BOUNCE;
      MODE_BOUNCE: nm = MODE_WALK;
      default:     nm = MODE_FILL;
    endcase
    return nm;
  endfunction

  // Turn (mode, position) into an LED vector of n LEDs, zero-extended to
  // MAX_LEDS. FILL is a thermometer code (pos LEDs lit from bit0), every
  // other mode is a single lit LED at index pos.
  function automatic logic [MAX_LEDS-1:0] decode_pattern(
    input logic [MODE_W-1:0]    mode,
    input logic [DEC_POS_W-1:0] pos,
    input int unsigned          n
  );
    logic [MAX_LEDS-1:0] one_hot;
    logic [MAX_LEDS-1:0] mask;
    logic [MAX_LEDS-1:0] pat;
    one_hot = {{(MAX_LEDS-1){1'b0}}, 1'b1} << pos;
    if (n >= MAX_LEDS) begin
      mask = {MAX_LEDS{1'b1}};
    end else begin
      mask = ({{(MAX_LEDS-1){1'b0}}, 1'b1} << n) - {{(MAX_LEDS-1){1'b0}}, 1'b1};
    end
    case (mode)
      MODE_FILL: pat = one_hot - {{(MAX_LEDS-1){1'b0}}, 1'b1};
      default:   pat = one_hot;
    endcase
    return pat & mask;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Cyclic auto-step timebase.
// While en is high the counter runs 0..CYCLE_TICKS-1 and wraps; tick is high
// during the terminal-count cycle. clr (or en low) forces the count back to 0,
// and a cleared cycle never produces a tick.
module led_tick_gen #(
  parameter int CYCLE_TICKS = 50
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLE_TICKS - 1);
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term_s;

  assign at_term_s = (cnt_q == TERM);
  assign tick      = en & ~clr & at_term_s;

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = ZERO;
    end else if (at_term_s) begin
      cnt_d = ZERO;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// LED pattern driver: N_LEDS registered outputs showing a WALK, FILL or
// BOUNCE pattern, stepped by button pulses or by a timed cyclic auto-step.
// Event priority in one cycle: mode change > cyclic toggle > manual step >
// auto-step; at most one state update per cycle.
// Build option: define LED_DIM_EN to gate the output with a free-running
// 3-bit slot counter (DIM_DUTY on-slots out of 8). Without it the output is
// the pattern register itself and no slot counter exists.
module led_pattern_driver
  import led_driver_pkg::*;
#(
  parameter int N_LEDS      = 5,
  parameter int CYCLE_TICKS = 50,
  parameter int DIM_DUTY    = 4
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic              next_led_re,
  input  logic              prev_led_re,
  input  logic              change_mode_re,
  input  logic              btn_cyclic_re,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        mode,
  output logic              cyclic_active
);

  localparam int POS_W = $clog2(N_LEDS + 1);
  localparam logic [POS_W-1:0] POS_ZERO  = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_FULL  = POS_W'(N_LEDS);
  localparam logic [N_LEDS-1:0] LED_RST  = N_LEDS'(1);

  // One forward step; returns {dir, pos}.
  function automatic logic [POS_W:0] step_fwd(
    input logic [MODE_W-1:0] m,
    input logic [POS_W-1:0]  p,
    input logic              d
  );
    logic [POS_W-1:0] np;
    logic             nd;
    np = p;
    nd = d;
    case (m)
      MODE_FILL: begin
        np = (p == POS_FULL) ? POS_ZERO : p + POS_ONE;
      end
      MODE_BOUNCE: begin
        if (d == DIR_UP) begin
          if (p == POS_LAST) begin
            nd = DIR_DOWN;
            np = p - POS_ONE;
          end else begin
            np = p + POS_ONE;
          end
        end else begin
          if (p == POS_ZERO) begin
            nd = DIR_UP;
            np = p + POS_ONE;
          end else begin
            np = p - POS_ONE;
          end
        end
      end
      default: begin
        np = (p == POS_LAST) ? POS_ZERO : p + POS_ONE;
      end
    endcase
    return {nd, np};
  endfunction

  // One backward step; returns {dir, pos}. Bounce keeps its direction and
  // saturates at both ends instead of reflecting.
  function automatic logic [POS_W:0] step_bwd(
    input logic [MODE_W-1:0] m,
    input logic [POS_W-1:0]  p,
    input logic              d
  );
    logic [POS_W-1:0] np;
    np = p;
    case (m)
      MODE_FILL: begin
        np = (p == POS_ZERO) ? POS_FULL : p - POS_ONE;
      end
      MODE_BOUNCE: begin
        if (d == DIR_UP) begin
          np = (p == POS_ZERO) ? POS_ZERO : p - POS_ONE;
        end else begin
          np = (p == POS_LAST) ? POS_LAST : p + POS_ONE;
        end
      end
      default: begin
        np = (p == POS_ZERO) ? POS_LAST : p - POS_ONE;
      end
    endcase
    return {d, np};
  endfunction

  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  pos_d;
  logic              dir_q;
  logic              dir_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic              cyc_q;
  logic              cyc_d;
  logic [N_LEDS-1:0] led_q;
  logic [N_LEDS-1:0] led_d;

  logic              manual_fwd_s;
  logic              manual_bwd_s;
  logic              tick_clr_s;
  logic              tick_s;
  logic [POS_W:0]    fwd_s;
  logic [POS_W:0]    bwd_s;
  logic [MAX_LEDS-1:0] pattern_full_s;
  logic [N_LEDS-1:0] pattern_s;

  // Simultaneous next and prev cancel each other out.
  assign manual_fwd_s = next_led_re & ~prev_led_re;
  assign manual_bwd_s = prev_led_re & ~next_led_re;

  // Any higher-priority event restarts the auto-step interval.
  assign tick_clr_s = change_mode_re | btn_cyclic_re | manual_fwd_s | manual_bwd_s;

  led_tick_gen #(
    .CYCLE_TICKS (CYCLE_TICKS)
  ) u_tick_gen (
    .clk          (clk),
    .async_nreset (async_nreset),
    .en           (cyc_q),
    .clr          (tick_clr_s),
    .tick         (tick_s)
  );

  assign fwd_s = step_fwd(mode_q, pos_q, dir_q);
  assign bwd_s = step_bwd(mode_q, pos_q, dir_q);

  // Prioritised next-state selection for position, direction, mode and cyclic flag.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    cyc_d  = cyc_q;
    if (change_mode_re) begin
      mode_d = next_mode(mode_q);
      pos_d  = POS_ZERO;
      dir_d  = DIR_UP;
    end else if (btn_cyclic_re) begin
      cyc_d = ~cyc_q;
    end else if (manual_fwd_s) begin
      {dir_d, pos_d} = fwd_s;
    end else if (manual_bwd_s) begin
      {dir_d, pos_d} = bwd_s;
    end else if (tick_s) begin
      {dir_d, pos_d} = fwd_s;
    end else begin
      pos_d = pos_q;
    end
  end

  // Decode the next pattern so the LED register updates in the same edge as the state.
  always_comb begin
    pattern_full_s = decode_pattern(mode_d,
                                    DEC_POS_W'(pos_d),
                                    N_LEDS);
    pattern_s      = pattern_full_s[N_LEDS-1:0];
  end

`ifdef LED_DIM_EN
  logic [2:0] slot_q;
  logic [2:0] slot_d;
  logic       slot_on_s;

  // Free-running slot counter and the on/off decision for the next slot.
  always_comb begin
    slot_d    = slot_q + 3'd1;
    slot_on_s = ({1'b0, slot_d} < 4'(DIM_DUTY));
    led_d     = pattern_s & {N_LEDS{slot_on_s}};
  end

  // Dimming slot register.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      slot_q <= 3'd0;
    end else begin
      slot_q <= slot_d;
    end
  end
`else
  // Output follows the pattern directly.
  always_comb begin
    led_d = pattern_s;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      pos_q  <= POS_ZERO;
      dir_q  <= DIR_UP;
      mode_q <= MODE_WALK;
      cyc_q  <= 1'b0;
      led_q  <= LED_RST;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      cyc_q  <= cyc_d;
      led_q  <= led_d;
    end
  end

  assign led           = led_q;
  assign mode          = mode_q;
  assign cyclic_active = cyc_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver (N_LEDS=5, CYCLE_TICKS=4,
// default build without LED_DIM_EN). A behavioural model tracks position,
// direction, mode and the auto-step interval as plain integers; a compare
// process checks the DUT against it on every falling edge, and directed
// sequences pin both DUT and model with literal expectations.
module tb_led_pattern_driver;

  localparam int N  = 5;
  localparam int CT = 4;

  logic         clk = 1'b0;
  logic         async_nreset = 1'b0;
  logic         next_led_re = 1'b0;
  logic         prev_led_re = 1'b0;
  logic         change_mode_re = 1'b0;
  logic         btn_cyclic_re = 1'b0;
  logic [N-1:0] led;
  logic [1:0]   mode;
  logic         cyclic_active;

  int checks   = 0;
  int failures = 0;

  led_pattern_driver #(
    .N_LEDS      (N),
    .CYCLE_TICKS (CT),
    .DIM_DUTY    (4)
  ) dut (
    .clk            (clk),
    .async_nreset   (async_nreset),
    .next_led_re    (next_led_re),
    .prev_led_re    (prev_led_re),
    .change_mode_re (change_mode_re),
    .btn_cyclic_re  (btn_cyclic_re),
    .led            (led),
    .mode           (mode),
    .cyclic_active  (cyclic_active)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_pos  = 0;   // lit index (WALK/BOUNCE) or number of lit LEDs (FILL)
  int m_down = 0;   // bounce heading towards index 0
  int m_mode = 0;
  int m_cyc  = 0;
  int m_wait = 0;   // cycles elapsed in the current auto-step interval

  function automatic logic [N-1:0] model_led();
    int v;
    if (m_mode == 1) v = (1 << m_pos) - 1;
    else             v = 1 << m_pos;
    return v[N-1:0];
  endfunction

  always @(posedge clk or negedge async_nreset) begin : model_upd
    int p, dn, md, c, w, fwd, bwd;
    if (!async_nreset) begin
      m_pos <= 0; m_down <= 0; m_mode <= 0; m_cyc <= 0; m_wait <= 0;
    end else begin
      p = m_pos; dn = m_down; md = m_mode; c = m_cyc; w = m_wait;
      fwd = 0; bwd = 0;
      if (change_mode_re) begin
        md = (m_mode + 1) % 3; p = 0; dn = 0; w = 0;
      end else if (btn_cyclic_re) begin
        c = 1 - c; w = 0;
      end else if (next_led_re != prev_led_re) begin
        w = 0; fwd = next_led_re; bwd = prev_led_re;
      end else if (c != 0) begin
        if (w == CT - 1) begin w = 0; fwd = 1; end
        else w = w + 1;
      end
      if (fwd != 0) begin
        if (md == 0) p = (p + 1) % N;
        else if (md == 1) p = (p + 1) % (N + 1);
        else if (dn == 0) begin
          if (p == N - 1) begin dn = 1; p = N - 2; end else p = p + 1;
        end else begin
          if (p == 0) begin dn = 0; p = 1; end else p = p - 1;
        end
      end
      if (bwd != 0) begin
        if (md == 0) p = (p + N - 1) % N;
        else if (md == 1) p = (p + N) % (N + 1);
        else if (dn == 0) p = (p > 0) ? p - 1 : 0;
        else p = (p < N - 1) ? p + 1 : N - 1;
      end
      m_pos <= p; m_down <= dn; m_mode <= md; m_cyc <= c; m_wait <= w;
    end
  end

  // ---------------- continuous compare ----------------
  always @(negedge clk) begin
    if (async_nreset) begin
      checks++;
      if (led !== model_led()) begin
        failures++;
        $display("FAIL model_led t=%0t: got %b expected %b", $time, led, model_led());
      end
      checks++;
      if (mode !== 2'(m_mode)) begin
        failures++;
        $display("FAIL model_mode t=%0t: got %0d expected %0d", $time, mode, m_mode);
      end
      checks++;
      if (cyclic_active !== 1'(m_cyc)) begin
        failures++;
        $display("FAIL model_cyc t=%0t: got %b expected %0d", $time, cyclic_active, m_cyc);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_led(input string nm, input logic [N-1:0] e);
    checks++;
    if (led !== e) begin
      failures++;
      $display("FAIL %s: led got %b expected %b", nm, led, e);
    end
    checks++;
    if (model_led() !== e) begin
      failures++;
      $display("FAIL %s_model: model led %b expected %b", nm, model_led(), e);
    end
  endtask

  task automatic expect_state(input string nm, input logic [1:0] md, input logic cy);
    checks++;
    if (mode !== md || cyclic_active !== cy) begin
      failures++;
      $display("FAIL %s: mode/cyclic got %0d/%b expected %0d/%b", nm, mode, cyclic_active, md, cy);
    end
  endtask

  // Drive one cycle of pulses starting at a falling edge; returns at the
  // next falling edge, where the effect of the sampling edge is visible.
  task automatic pulse(input logic n, input logic p, input logic c, input logic b);
    next_led_re = n; prev_led_re = p; change_mode_re = c; btn_cyclic_re = b;
    @(negedge clk);
    next_led_re = 1'b0; prev_led_re = 1'b0; change_mode_re = 1'b0; btn_cyclic_re = 1'b0;
  endtask

  logic [N-1:0] walk_seq [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [N-1:0] fill_seq [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};
  logic [N-1:0] bnc_seq  [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                 5'b00100, 5'b00010, 5'b00001, 5'b00010};

  initial begin
    repeat (2) @(negedge clk);
    async_nreset = 1'b1;
    @(negedge clk);
    expect_led("reset_led", 5'b00001);
    expect_state("reset_state", 2'd0, 1'b0);

    // WALK forward around the ring
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      expect_led($sformatf("walk_next%0d", i), walk_seq[i]);
    end
    expect_state("walk_state", 2'd0, 1'b0);

    // WALK backward wrap, then cancelling next+prev
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    expect_led("walk_prev_wrap", 5'b10000);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    expect_led("walk_next_prev", 5'b10000);

    // FILL
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_led("fill_enter", 5'b00000);
    expect_state("fill_state", 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      expect_led($sformatf("fill_next%0d", i), fill_seq[i]);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    expect_led("fill_prev_wrap", 5'b11111);

    // BOUNCE with cyclic auto-step every CT cycles
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_led("bounce_enter", 5'b00001);
    expect_state("bounce_state", 2'd2, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    expect_state("cyc_on", 2'd2, 1'b1);
    for (int i = 0; i < 9; i++) begin
      repeat (CT - 1) @(negedge clk);
      expect_led($sformatf("bounce_hold%0d", i), (i == 0) ? 5'b00001 : bnc_seq[i-1]);
      @(negedge clk);
      expect_led($sformatf("bounce_auto%0d", i), bnc_seq[i]);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    expect_state("cyc_off", 2'd2, 1'b0);
    repeat (20) @(negedge clk);
    expect_led("bounce_frozen", 5'b00010);

    // Mode change beats a same-cycle step
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    expect_led("mode_beats_next", 5'b00001);
    expect_state("mode_wrap_walk", 2'd0, 1'b0);

    // Manual step at the auto terminal count: one step, interval restarts
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (CT - 1) @(negedge clk);
    expect_led("pre_terminal", 5'b00001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_led("manual_at_term", 5'b00010);
    repeat (CT - 1) @(negedge clk);
    expect_led("interval_restart", 5'b00010);
    @(negedge clk);
    expect_led("auto_after_manual", 5'b00100);

    // Asynchronous reset in the middle of cyclic operation
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_state("fill_keep_cyc", 2'd1, 1'b1);
    @(negedge clk);
    #2 async_nreset = 1'b0;
    #1;
    expect_led("async_reset_led", 5'b00001);
    expect_state("async_reset_state", 2'd0, 1'b0);
    @(negedge clk);
    async_nreset = 1'b1;
    repeat (20) @(negedge clk);
    expect_led("post_reset_idle", 5'b00001);
    expect_state("post_reset_state", 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
